// File: rtl/seg7_scan_capture_if.sv
// Bus between a multiplexed 7-segment display tap and the capture engine.
// Signal names follow the block's external pin names.
interface seg7_scan_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              i_seg;
  logic [NUM_DIGITS-1:0]   i_dig_en;
  logic                    i_capture;
  logic [4*NUM_DIGITS-1:0] o_value;
  logic                    o_valid;
  logic                    o_err;
  logic                    o_timeout;
  logic                    o_busy;

  modport master (
    output i_seg, i_dig_en, i_capture,
    input  o_value, o_valid, o_err, o_timeout, o_busy
  );

  modport slave (
    input  i_seg, i_dig_en, i_capture,
    output o_value, o_valid, o_err, o_timeout, o_busy
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Samples a scanned 7-segment display and reassembles one full hex frame per
// capture request, accepting each digit only after it has been stable.
module seg7_scan_capture #(
  parameter int NUM_DIGITS           = 4,
  parameter int COMMON_ANODE_CATHODE = 0,
  parameter int STABLE_CYCLES        = 4,
  parameter int TIMEOUT_CYCLES       = 65535
) (
  input logic               i_clk,
  input logic               i_rst_n,
  seg7_scan_capture_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t state, next_state;

  logic [6:0]              seg_q, seg_prev;
  logic [NUM_DIGITS-1:0]   dig_q, dig_prev;
  logic [7:0]              stab_cnt, stab_next;
  logic [TW-1:0]           tmo_cnt, tmo_next;
  logic [NUM_DIGITS-1:0]   flags, flags_next, capture_mask;
  logic [4*NUM_DIGITS-1:0] frame_value, value;
  logic                    frame_err, err, valid, timeout;
  logic                    one_hot, same, accept, finish_ok, finish_tmo;
  logic [6:0]              seg_fix;
  logic [4:0]              dec;

  // {valid, nibble}; invalid patterns decode to nibble 0.
  function automatic logic [4:0] decode7(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F: r = 5'h10;  7'h06: r = 5'h11;  7'h5B: r = 5'h12;  7'h4F: r = 5'h13;
      7'h66: r = 5'h14;  7'h6D: r = 5'h15;  7'h7D: r = 5'h16;  7'h07: r = 5'h17;
      7'h7F: r = 5'h18;  7'h6F: r = 5'h19;  7'h77: r = 5'h1A;  7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;  7'h5E: r = 5'h1D;  7'h79: r = 5'h1E;  7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign seg_fix = (COMMON_ANODE_CATHODE != 0) ? ~seg_q : seg_q;
  assign dec     = decode7(seg_fix);
  assign one_hot = $onehot(dig_q);
  assign same    = ({dig_q, seg_q} == {dig_prev, seg_prev});

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    stab_next = 8'd0;
    if (one_hot) begin
      if (!same)                    stab_next = 8'd1;
      else if (stab_cnt >= STABLE_MAX) stab_next = STABLE_MAX;
      else                          stab_next = stab_cnt + 8'd1;
    end
  end

  assign accept       = (state == CAPTURE) && one_hot && (stab_next == STABLE_MAX);
  assign capture_mask = accept ? (dig_q & ~flags) : '0;
  assign flags_next   = flags | capture_mask;
  assign tmo_next     = tmo_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Completion is judged on the registered flags; a digit landing on the
  // timeout edge still completes the frame one cycle later.
  always_comb begin
    next_state = state;
    finish_ok  = 1'b0;
    finish_tmo = 1'b0;
    case (state)
      IDLE: if (bus.i_capture) next_state = CAPTURE;
      CAPTURE: begin
        if (&flags) begin
          next_state = IDLE;
          finish_ok  = 1'b1;
        end else if ((tmo_next == TMO_MAX) && !(&flags_next)) begin
          next_state = IDLE;
          finish_tmo = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the frame
  // buffer is reset too, so nothing in the block powers up undefined.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seg_q       <= '0;
      seg_prev    <= '0;
      dig_q       <= '0;
      dig_prev    <= '0;
      stab_cnt    <= '0;
      tmo_cnt     <= '0;
      flags       <= '0;
      frame_err   <= 1'b0;
      frame_value <= '0;
      value       <= '0;
      err         <= 1'b0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      seg_q    <= bus.i_seg;
      dig_q    <= bus.i_dig_en;
      seg_prev <= seg_q;
      dig_prev <= dig_q;
      valid    <= finish_ok;
      timeout  <= finish_tmo;
      if (finish_ok) begin
        value <= frame_value;
        err   <= frame_err;
      end
      // Holding everything cleared in IDLE gives a fresh frame on entry.
      if (state == IDLE) begin
        stab_cnt  <= '0;
        tmo_cnt   <= '0;
        flags     <= '0;
        frame_err <= 1'b0;
      end else begin
        stab_cnt <= stab_next;
        tmo_cnt  <= tmo_next;
        flags    <= flags_next;
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (capture_mask[k]) frame_value[4*k +: 4] <= dec[3:0];
        end
        if ((|capture_mask) && !dec[4]) frame_err <= 1'b1;
      end
    end
  end

  assign bus.o_value   = value;
  assign bus.o_valid   = valid;
  assign bus.o_err     = err;
  assign bus.o_timeout = timeout;
  assign bus.o_busy    = (state == CAPTURE);

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench: two instances (active-high and active-low segments) share
// one stimulus stream; sel picks which instance's outputs are observed.
module tb_seg7_scan_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg = '0;
  logic [3:0] dig_en = '0;
  logic       capture = 1'b0;
  logic       sel = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int tmo_cnt = 0;
  logic        rearm = 1'b0;
  logic        rearm_fire = 1'b0;
  logic        rearm_busy = 1'b0;
  logic [15:0] last_value = '0;
  logic        last_err = 1'b0;
  logic [6:0]  pat [4];

  seg7_scan_capture_if #(.NUM_DIGITS(4)) bus0 ();
  seg7_scan_capture_if #(.NUM_DIGITS(4)) bus1 ();

  assign bus0.i_seg = seg;  assign bus0.i_dig_en = dig_en;  assign bus0.i_capture = capture;
  assign bus1.i_seg = seg;  assign bus1.i_dig_en = dig_en;  assign bus1.i_capture = capture;

  seg7_scan_capture #(.NUM_DIGITS(4), .COMMON_ANODE_CATHODE(0), .STABLE_CYCLES(4),
                      .TIMEOUT_CYCLES(100)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
  seg7_scan_capture #(.NUM_DIGITS(4), .COMMON_ANODE_CATHODE(1), .STABLE_CYCLES(4),
                      .TIMEOUT_CYCLES(100)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

  logic [15:0] obs_value;
  logic        obs_valid, obs_err, obs_timeout, obs_busy;
  assign obs_value   = sel ? bus1.o_value   : bus0.o_value;
  assign obs_valid   = sel ? bus1.o_valid   : bus0.o_valid;
  assign obs_err     = sel ? bus1.o_err     : bus0.o_err;
  assign obs_timeout = sel ? bus1.o_timeout : bus0.o_timeout;
  assign obs_busy    = sel ? bus1.o_busy    : bus0.o_busy;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock, then observe 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rearm_fire) begin
      rearm_fire = 1'b0;
      capture    = 1'b0;
      rearm_busy = obs_busy;
    end
    if (obs_valid) begin
      valid_cnt++;
      last_value = obs_value;
      last_err   = obs_err;
      if (rearm) begin
        rearm      = 1'b0;
        rearm_fire = 1'b1;
        capture    = 1'b1;
      end
    end
    if (obs_timeout) tmo_cnt++;
  endtask

  task automatic start_frame();
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    dig_en = d;
    seg    = s;
    repeat (n) tick();
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                      input logic [6:0] p3, input logic inv, input int rounds);
    logic [6:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int r = 0; r < rounds; r++)
      for (int k = 0; k < 4; k++)
        hold(4'(1 << k), inv ? ~p[k] : p[k], 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vbase, tbase, busy_cycles, tmo_at, idx;
    logic busy_at_tmo;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_value",   32'(bus0.o_value), 32'h0);
    check("rst_valid",   32'(bus0.o_valid), 32'h0);
    check("rst_err",     32'(bus0.o_err), 32'h0);
    check("rst_timeout", 32'(bus0.o_timeout), 32'h0);
    check("rst_busy",    32'(bus0.o_busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic frame: digits 3,2,1,0 on positions 0..3
    vbase = valid_cnt;
    start_frame();
    check("busy_after_req", 32'(obs_busy), 32'h1);
    scan(7'h4F, 7'h5B, 7'h06, 7'h3F, 1'b0, 2);
    check("f1_valid_pulses", 32'(valid_cnt - vbase), 32'd1);
    check("f1_value", 32'(last_value), 32'h0123);
    check("f1_err", 32'(last_err), 32'h0);
    check("f1_busy_idle", 32'(obs_busy), 32'h0);

    // Timeout: pattern changes every 3 cycles, never reaches 4 stable samples
    pat[0] = 7'h4F; pat[1] = 7'h5B; pat[2] = 7'h06; pat[3] = 7'h3F;
    vbase = valid_cnt;
    tbase = tmo_cnt;
    tmo_at = -1;
    busy_at_tmo = 1'b1;
    start_frame();
    busy_cycles = obs_busy ? 1 : 0;
    for (int i = 0; i < 120; i++) begin
      idx = (i / 3) % 4;
      dig_en = 4'(1 << idx);
      seg = pat[idx];
      tick();
      if (obs_busy) busy_cycles++;
      if (obs_timeout && tmo_at < 0) begin
        tmo_at = busy_cycles;
        busy_at_tmo = obs_busy;
      end
    end
    check("tmo_pulses", 32'(tmo_cnt - tbase), 32'd1);
    check("tmo_busy_cycles", 32'(tmo_at), 32'd100);
    check("tmo_busy_fell", 32'(busy_at_tmo), 32'h0);
    check("tmo_no_valid", 32'(valid_cnt - vbase), 32'd0);
    check("tmo_value_held", 32'(obs_value), 32'h0123);
    check("tmo_err_held", 32'(obs_err), 32'h0);

    // Invalid pattern on digit 2
    vbase = valid_cnt;
    start_frame();
    scan(7'h06, 7'h5B, 7'h7E, 7'h4F, 1'b0, 2);
    check("inv_valid_pulses", 32'(valid_cnt - vbase), 32'd1);
    check("inv_nibble2", 32'(last_value[11:8]), 32'h0);
    check("inv_value", 32'(last_value), 32'h3021);
    check("inv_err", 32'(last_err), 32'h1);

    // Multi-hot select never captures; then a clean scan completes and
    // a request in the o_valid cycle opens the next frame immediately.
    vbase = valid_cnt;
    start_frame();
    hold(4'b0110, 7'h06, 20);
    check("mh_still_busy", 32'(obs_busy), 32'h1);
    check("mh_no_valid", 32'(valid_cnt - vbase), 32'd0);
    rearm = 1'b1;
    scan(7'h3F, 7'h06, 7'h5B, 7'h4F, 1'b0, 1);
    check("mh_valid_pulses", 32'(valid_cnt - vbase), 32'd1);
    check("mh_value", 32'(last_value), 32'h3210);
    check("mh_err_cleared", 32'(last_err), 32'h0);
    check("rearm_taken", 32'(rearm), 32'h0);
    check("rearm_busy", 32'(rearm_busy), 32'h1);

    // Reset mid-capture after two digits
    vbase = valid_cnt;
    hold(4'b0001, 7'h3F, 8);
    hold(4'b0010, 7'h06, 8);
    check("pre_rst_busy", 32'(obs_busy), 32'h1);
    check("pre_rst_no_valid", 32'(valid_cnt - vbase), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_value",   32'(bus0.o_value), 32'h0);
    check("mid_rst_valid",   32'(bus0.o_valid), 32'h0);
    check("mid_rst_err",     32'(bus0.o_err), 32'h0);
    check("mid_rst_timeout", 32'(bus0.o_timeout), 32'h0);
    check("mid_rst_busy",    32'(bus0.o_busy), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // After release only digits 2,3 shown: frame stays open; a request while
    // busy is ignored; later patterns on 2,3 lose to the first ones.
    vbase = valid_cnt;
    start_frame();
    hold(4'b0100, 7'h5B, 8);
    hold(4'b1000, 7'h4F, 8);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    check("partial_busy", 32'(obs_busy), 32'h1);
    check("partial_no_valid", 32'(valid_cnt - vbase), 32'd0);
    scan(7'h77, 7'h7C, 7'h39, 7'h5E, 1'b0, 2);
    check("post_rst_valid_pulses", 32'(valid_cnt - vbase), 32'd1);
    check("post_rst_value", 32'(last_value), 32'h32BA);
    check("post_rst_err", 32'(last_err), 32'h0);

    // Active-low segments on the second instance
    sel = 1'b1;
    repeat (2) tick();
    vbase = valid_cnt;
    start_frame();
    scan(7'h7C, 7'h3F, 7'h3F, 7'h3F, 1'b1, 2);
    check("pol_valid_pulses", 32'(valid_cnt - vbase), 32'd1);
    check("pol_value", 32'(last_value), 32'h000B);
    check("pol_err", 32'(last_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
